ext_int_ctrl: RTL and testbench

- External interrupt controller that sits directly upstream of the core's `ext_int` input.
- Latches edges from up to NUM_SRC peripheral interrupt lines into pending bits and masks them with an enable register.
- Drives a single registered `ext_int` level into the core.
- Software manages it through a 4-word register port with a claim/complete handshake, so only one source is in service at a time.

---
 rtl/ext_int_ctrl_pkg.sv | 15 +
 rtl/ext_int_prio_enc.sv | 22 ++
 rtl/ext_int_ctrl.sv | 122 ++++++++++++
 tb/tb_ext_int_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ext_int_ctrl_pkg.sv
// Shared constants for the external interrupt controller: register map, "no source" id
// and the default source count.
package ext_int_ctrl_pkg;

    typedef enum logic [1:0] {
        EXT_INT_REG_PENDING  = 2'd0,
        EXT_INT_REG_ENABLE   = 2'd1,
        EXT_INT_REG_CLAIM    = 2'd2,
        EXT_INT_REG_COMPLETE = 2'd3
    } ext_int_reg_e;

    localparam logic [4:0] EXT_INT_ID_NONE = 5'd0;
    localparam int         EXT_INT_NUM_SRC = 8;

endpackage

// File: rtl/ext_int_prio_enc.sv
// Fixed-priority encoder: returns the 1-based id of the lowest set request bit,
// or EXT_INT_ID_NONE when no bit is set.
module ext_int_prio_enc
    import ext_int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = EXT_INT_NUM_SRC
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [4:0]         id
);

    // Scan from the top down so the lowest index is the last, and winning, assignment.
    always_comb begin
        id = EXT_INT_ID_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 5'(i + 1);
            end
        end
    end

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: edge-latched pending bits, enable mask, claim/complete
// service tracking, registered ext_int. Define EXT_INT_CTRL_SYNC_EN to add 2-flop src synchronizers.
module ext_int_ctrl
    import ext_int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = EXT_INT_NUM_SRC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic               enable_n,
    input  logic               is_write,
    input  logic [1:0]         addr,
    input  logic [31:0]        in,
    output logic [31:0]        out,
    output logic               ext_int
);

    logic [NUM_SRC-1:0] src_eff;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] clr_mask;
    logic [4:0]         in_service_id;
    logic [4:0]         claim_id;
    logic [31:0]        rd_data;
    logic               rd;
    logic               wr;
    logic               claim_take;
    logic               complete_hit;
    logic               unused_in;

`ifdef EXT_INT_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

    assign src_eff = sync2;
`else
    assign src_eff = src;
`endif

    // Register port: one access per cycle while enable_n is low; is_write/addr/in are
    // sampled at that edge, reads land in out at the same edge, and there is no stall.
    assign rd        = ~enable_n & ~is_write;
    assign wr        = ~enable_n & is_write;
    assign rise      = src_eff & ~src_q;
    assign active    = pending & enable;
    assign unused_in = ^in;

    ext_int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req (active),
        .id  (claim_id)
    );

    assign claim_take   = rd && (addr == EXT_INT_REG_CLAIM) &&
                          (in_service_id == EXT_INT_ID_NONE) && (claim_id != EXT_INT_ID_NONE);
    assign complete_hit = wr && (addr == EXT_INT_REG_COMPLETE) &&
                          (in_service_id != EXT_INT_ID_NONE) && (in[4:0] == in_service_id);

    always_comb begin
        clr_mask = '0;
        if (wr && (addr == EXT_INT_REG_PENDING)) begin
            clr_mask = in[NUM_SRC-1:0];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claim_take && (claim_id == 5'(i + 1))) begin
                clr_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (ext_int_reg_e'(addr))
            EXT_INT_REG_PENDING:  rd_data = 32'(pending);
            EXT_INT_REG_ENABLE:   rd_data = 32'(enable);
            EXT_INT_REG_CLAIM:    rd_data = (in_service_id == EXT_INT_ID_NONE) ? 32'(claim_id) : '0;
            EXT_INT_REG_COMPLETE: rd_data = 32'(in_service_id);
            default:              rd_data = '0;
        endcase
    end

    // A rise is OR-ed in after the clear so a same-cycle set always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q         <= '0;
            pending       <= '0;
            enable        <= '0;
            in_service_id <= EXT_INT_ID_NONE;
            out           <= '0;
            ext_int       <= 1'b0;
        end else begin
            src_q   <= src_eff;
            pending <= (pending & ~clr_mask) | rise;
            if (wr && (addr == EXT_INT_REG_ENABLE)) begin
                enable <= in[NUM_SRC-1:0];
            end
            if (claim_take) begin
                in_service_id <= claim_id;
            end else if (complete_hit) begin
                in_service_id <= EXT_INT_ID_NONE;
            end
            if (rd) begin
                out <= rd_data;
            end
            ext_int <= (|active) && (in_service_id == EXT_INT_ID_NONE);
        end
    end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: latency probe, a vector table of register traffic
// with per-cycle ext_int expectations, and a mid-claim reset sequence.
module tb_ext_int_ctrl;
    import ext_int_ctrl_pkg::*;

`ifdef EXT_INT_CTRL_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int NVEC = 52;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  src = '0;
    logic        enable_n = 1'b1;
    logic        is_write = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] in = '0;
    logic [31:0] out;
    logic        ext_int;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        acc;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [7:0]  src;
        logic        chk_out;
        logic [31:0] exp_out;
        logic        exp_ext;
    } vec_t;

    vec_t vec[NVEC];

    ext_int_ctrl #(.NUM_SRC(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .src      (src),
        .enable_n (enable_n),
        .is_write (is_write),
        .addr     (addr),
        .in       (in),
        .out      (out),
        .ext_int  (ext_int)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1 ns after the rising edge.
    task automatic step(input logic a, input logic w, input logic [1:0] ad,
                        input logic [31:0] d, input logic [7:0] s, input logic rst);
        @(negedge clk);
        reset    = rst;
        enable_n = ~a;
        is_write = w;
        addr     = ad;
        in       = d;
        src      = s;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic a, input logic w, input logic [1:0] ad,
                                input logic [31:0] d, input logic [7:0] s,
                                input logic co, input logic [31:0] eo, input logic ee);
        vec_t v;
        v.acc = a; v.wr = w; v.addr = ad; v.din = d; v.src = s;
        v.chk_out = co; v.exp_out = eo; v.exp_ext = ee;
        return v;
    endfunction

    task automatic do_reset();
        step(1'b0, 1'b0, 2'd0, 32'd0, 8'h00, 1'b1);
        chk("reset_out", out, 32'd0);
        chk("reset_ext_int", 32'(ext_int), 32'd0);
    endtask

    initial begin
        logic [1:0] P, E, C, D;
        int first_pend, first_ext, sidx;
        logic [31:0] e;
        P = EXT_INT_REG_PENDING; E = EXT_INT_REG_ENABLE;
        C = EXT_INT_REG_CLAIM;   D = EXT_INT_REG_COMPLETE;

        // Single source, claim and complete
        vec[0]  = mk(1, 1, E, 32'h01, 8'h00, 0, 0, 0);
        vec[1]  = mk(0, 0, P, 0, 8'h01, 0, 0, 0);
        vec[2]  = mk(0, 0, P, 0, 8'h01, 0, 0, 1);
        vec[3]  = mk(1, 0, P, 0, 8'h01, 1, 32'h01, 1);
        vec[4]  = mk(1, 0, C, 0, 8'h01, 1, 32'd1, 1);
        vec[5]  = mk(0, 0, P, 0, 8'h01, 0, 0, 0);
        vec[6]  = mk(1, 0, P, 0, 8'h01, 1, 32'h00, 0);
        vec[7]  = mk(1, 0, D, 0, 8'h01, 1, 32'd1, 0);
        vec[8]  = mk(1, 1, D, 32'd1, 8'h01, 0, 0, 0);
        vec[9]  = mk(1, 0, D, 0, 8'h01, 1, 32'd0, 0);
        // Two simultaneous sources, priority order
        vec[10] = mk(1, 1, E, 32'hFF, 8'h00, 0, 0, 0);
        vec[11] = mk(0, 0, P, 0, 8'h24, 0, 0, 0);
        vec[12] = mk(1, 0, C, 0, 8'h24, 1, 32'd3, 1);
        vec[13] = mk(0, 0, P, 0, 8'h24, 0, 0, 0);
        vec[14] = mk(1, 1, D, 32'd3, 8'h24, 0, 0, 0);
        vec[15] = mk(0, 0, P, 0, 8'h24, 0, 0, 1);
        vec[16] = mk(1, 0, C, 0, 8'h24, 1, 32'd6, 1);
        vec[17] = mk(1, 1, D, 32'd6, 8'h24, 0, 0, 0);
        vec[18] = mk(1, 0, C, 0, 8'h24, 1, 32'd0, 0);
        // Disabled source latches, becomes visible when enabled; upper enable bits dropped
        vec[19] = mk(1, 1, E, 32'h00, 8'h00, 0, 0, 0);
        vec[20] = mk(0, 0, P, 0, 8'h10, 0, 0, 0);
        vec[21] = mk(1, 0, P, 0, 8'h10, 1, 32'h10, 0);
        vec[22] = mk(1, 1, E, 32'hFFFF_FF10, 8'h10, 0, 0, 0);
        vec[23] = mk(0, 0, P, 0, 8'h10, 0, 0, 1);
        vec[24] = mk(1, 0, E, 0, 8'h10, 1, 32'h10, 1);
        vec[25] = mk(1, 1, P, 32'h10, 8'h10, 0, 0, 1);
        vec[26] = mk(0, 0, P, 0, 8'h10, 0, 0, 0);
        vec[27] = mk(1, 0, P, 0, 8'h10, 1, 32'h00, 0);
        // Set beats W1C clear and claim clear in the same cycle
        vec[28] = mk(1, 1, E, 32'h06, 8'h00, 0, 0, 0);
        vec[29] = mk(0, 0, P, 0, 8'h02, 0, 0, 0);
        vec[30] = mk(0, 0, P, 0, 8'h00, 0, 0, 1);
        vec[31] = mk(1, 1, P, 32'h02, 8'h02, 0, 0, 1);
        vec[32] = mk(1, 0, P, 0, 8'h02, 1, 32'h02, 1);
        vec[33] = mk(0, 0, P, 0, 8'h00, 0, 0, 1);
        vec[34] = mk(1, 0, C, 0, 8'h02, 1, 32'd2, 1);
        vec[35] = mk(1, 0, P, 0, 8'h02, 1, 32'h02, 0);
        vec[36] = mk(1, 1, D, 32'd2, 8'h02, 0, 0, 0);
        vec[37] = mk(0, 0, P, 0, 8'h02, 0, 0, 1);
        vec[38] = mk(1, 1, P, 32'h02, 8'h02, 0, 0, 1);
        vec[39] = mk(0, 0, P, 0, 8'h02, 0, 0, 0);
        // In-service blocking, wrong-id complete, claim alongside another edge
        vec[40] = mk(1, 1, E, 32'h07, 8'h00, 0, 0, 0);
        vec[41] = mk(0, 0, P, 0, 8'h01, 0, 0, 0);
        vec[42] = mk(1, 0, C, 0, 8'h05, 1, 32'd1, 1);
        vec[43] = mk(1, 0, C, 0, 8'h05, 1, 32'd0, 0);
        vec[44] = mk(1, 0, P, 0, 8'h05, 1, 32'h04, 0);
        vec[45] = mk(1, 1, D, 32'd2, 8'h05, 0, 0, 0);
        vec[46] = mk(1, 0, D, 0, 8'h05, 1, 32'd1, 0);
        vec[47] = mk(1, 1, D, 32'd1, 8'h05, 0, 0, 0);
        vec[48] = mk(0, 0, P, 0, 8'h05, 0, 0, 1);
        vec[49] = mk(1, 1, C, 32'd0, 8'h05, 0, 0, 1);
        vec[50] = mk(1, 0, D, 0, 8'h05, 1, 32'd0, 1);
        vec[51] = mk(1, 0, C, 0, 8'h05, 1, 32'd3, 1);

        do_reset();

        // Latency probe: src[0] rises in step 0, PENDING read every cycle.
        step(1, 1, E, 32'h01, 8'h00, 0);
        first_pend = -1;
        first_ext  = -1;
        for (int k = 0; k < 10; k++) begin
            step(1, 0, P, 0, 8'h01, 0);
            if (first_pend < 0 && out[0]) first_pend = k;
            if (first_ext < 0 && ext_int) first_ext = k;
        end
        chk("lat_pending", 32'(first_pend), 32'(1 + SYNC_LAT));
        chk("lat_ext_int", 32'(first_ext), 32'(1 + SYNC_LAT));

        do_reset();

        // src is applied SYNC_LAT rows early so the table sees the same effective timing.
        for (int i = 0; i < NVEC; i++) begin
            sidx = (i + SYNC_LAT < NVEC) ? i + SYNC_LAT : NVEC - 1;
            if (vec[i].chk_out) exp_q.push_back(vec[i].exp_out);
            step(vec[i].acc, vec[i].wr, vec[i].addr, vec[i].din, vec[sidx].src, 0);
            if (vec[i].chk_out) begin
                e = exp_q.pop_front();
                chk($sformatf("vec%0d_out", i), out, e);
            end
            chk($sformatf("vec%0d_ext_int", i), 32'(ext_int), 32'(vec[i].exp_ext));
        end

        // Reset mid-claim with pending=0xA5 (id 3 still in service from the table).
        for (int k = 0; k < 1 + SYNC_LAT; k++) step(0, 0, P, 0, 8'h00, 0);
        step(0, 0, P, 0, 8'hA5, 0);
        for (int k = 0; k < SYNC_LAT; k++) step(0, 0, P, 0, 8'hA5, 0);
        step(1, 0, P, 0, 8'hA5, 0);
        chk("pre_reset_pending", out, 32'hA5);
        chk("pre_reset_ext_int", 32'(ext_int), 32'd0);
        step(1, 0, C, 0, 8'h00, 1);
        chk("mid_claim_reset_out", out, 32'd0);
        chk("mid_claim_reset_ext_int", 32'(ext_int), 32'd0);
        step(1, 0, P, 0, 8'h00, 0);
        chk("post_reset_pending", out, 32'd0);
        step(1, 0, E, 0, 8'h00, 0);
        chk("post_reset_enable", out, 32'd0);
        step(1, 0, D, 0, 8'h00, 0);
        chk("post_reset_in_service", out, 32'd0);
        step(1, 0, C, 0, 8'h00, 0);
        chk("post_reset_claim", out, 32'd0);
        chk("post_reset_ext_int", 32'(ext_int), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
